// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Purpose: sequences single ALU test commands. It drives an accepted command's
// operands and opcode onto an external combinational ALU. After SETTLE_CYCLES
// clock edges it samples the ALU result and compares it against the expected
// value. It then offers the outcome as a response and keeps saturating
// pass/fail tallies.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_a, cmd_b      4-bit operands
//   cmd_op            3-bit ALU operation code
//   cmd_expect        expected 4-bit ALU result
//   alu_a, alu_b      operands driven to the ALU (held until next accept)
//   alu_ctrl          ALUControl driven to the ALU
//   alu_result        combinational result returned by the ALU
//   rsp_valid/ready   response handshake
//   rsp_result        captured ALU result
//   rsp_pass          captured result matched the expected value
//   clear_counts      synchronous clear of both tallies (wins over increment)
//   pass_count        saturating count of passing comparisons
//   fail_count        saturating count of failing comparisons
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter  int unsigned SETTLE_CYCLES = 1,
   localparam int unsigned DATA_W        = 4,
   localparam int unsigned OP_W          = 3,
   localparam int unsigned CNT_W         = 4,
   localparam int unsigned TALLY_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [DATA_W-1:0]  cmd_a,
   input  logic [DATA_W-1:0]  cmd_b,
   input  logic [OP_W-1:0]    cmd_op,
   input  logic [DATA_W-1:0]  cmd_expect,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [OP_W-1:0]    alu_ctrl,
   input  logic [DATA_W-1:0]  alu_result,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_result,
   output logic               rsp_pass,
   input  logic               clear_counts,
   output logic [TALLY_W-1:0] pass_count,
   output logic [TALLY_W-1:0] fail_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
   localparam logic [TALLY_W-1:0] TALLY_MAX   = {TALLY_W{1'b1}};

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   settle_q;
   logic [CNT_W-1:0]   settle_d;
   logic [DATA_W-1:0]  expect_q;
   logic               accept;
   logic               capture;
   logic               cmd_ready_d;
   logic               rsp_valid_d;
   logic               result_match;

   assign result_match = (alu_result == expect_q);

   // State, settle counter and handshake flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         settle_q  <= '0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         cmd_ready <= cmd_ready_d;
         rsp_valid <= rsp_valid_d;
      end
   end

   // Next-state, settle countdown and datapath strobes
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      accept   = 1'b0;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               accept   = 1'b1;
               settle_d = SETTLE_LOAD;
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            // Last settle edge: sample the ALU this edge. "<=" also covers a zero load.
            if (settle_q <= CNT_W'(1)) begin
               capture = 1'b1;
               state_d = RESP;
            end else begin
               settle_d = CNT_W'(settle_q - CNT_W'(1));
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   // Command launch registers; these hold their values until the next accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_ctrl <= '0;
         expect_q <= '0;
      end else if (accept) begin
         alu_a    <= cmd_a;
         alu_b    <= cmd_b;
         alu_ctrl <= cmd_op;
         expect_q <= cmd_expect;
      end
   end

   // Response capture; the captured values are held through RESP and IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_result <= '0;
         rsp_pass   <= 1'b0;
      end else if (capture) begin
         rsp_result <= alu_result;
         rsp_pass   <= result_match;
      end
   end

   // Saturating tallies; a clear on the same edge discards that edge's increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_count <= '0;
         fail_count <= '0;
      end else if (clear_counts) begin
         pass_count <= '0;
         fail_count <= '0;
      end else if (capture) begin
         if (result_match && (pass_count != TALLY_MAX)) begin
            pass_count <= TALLY_W'(pass_count + TALLY_W'(1));
         end
         if (!result_match && (fail_count != TALLY_MAX)) begin
            fail_count <= TALLY_W'(fail_count + TALLY_W'(1));
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Purpose: self-checking bench for alu_op_sequencer. It instantiates a
// SETTLE_CYCLES=1 unit and a SETTLE_CYCLES=4 unit, each attached to a
// behavioural ALU. Responses and tallies are checked against an
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   // Unit 1: SETTLE_CYCLES = 1
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_a = '0, cmd_b = '0, cmd_expect = '0;
   logic [2:0] cmd_op = '0;
   logic [3:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_ctrl;
   logic       rsp_valid, rsp_pass;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_result;
   logic       clear_counts = 1'b0;
   logic [7:0] pass_count, fail_count;

   // Unit 2: SETTLE_CYCLES = 4
   logic       c2_valid = 1'b0;
   logic       c2_ready;
   logic [3:0] c2_a = '0, c2_b = '0, c2_expect = '0;
   logic [2:0] c2_op = '0;
   logic [3:0] a2_a, a2_b, a2_result;
   logic [2:0] a2_ctrl;
   logic       r2_valid, r2_pass;
   logic       r2_ready = 1'b0;
   logic [3:0] r2_result;
   logic       c2_clear = 1'b0;
   logic [7:0] p2_count, f2_count;

   int checks = 0;
   int errors = 0;
   int pass_m = 0;
   int fail_m = 0;

   always #5 clk = ~clk;

   // Behavioural ALU attached to each unit (gate-style expression)
   function automatic logic [3:0] hw_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return 4'(a + b);
         3'b011:  return 4'(a - b);
         3'b100:  return a ^ b;
         3'b101:  return ~(a | b);
         3'b110:  return ~(a & b);
         default: return ~a;
      endcase
   endfunction

   assign alu_result = hw_alu(alu_a, alu_b, alu_ctrl);
   assign a2_result  = hw_alu(a2_a, a2_b, a2_ctrl);

   // Reference model: integer arithmetic on 0..15
   function automatic int model_alu(input int a, input int b, input int op);
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return (a + b) % 16;
         3:       return (a - b + 16) % 16;
         4:       return a ^ b;
         5:       return 15 - (a | b);
         6:       return 15 - (a & b);
         default: return 15 - a;
      endcase
   endfunction

   alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_expect(cmd_expect),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_pass(rsp_pass),
      .clear_counts(clear_counts), .pass_count(pass_count), .fail_count(fail_count)
   );

   alu_op_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .cmd_valid(c2_valid), .cmd_ready(c2_ready),
      .cmd_a(c2_a), .cmd_b(c2_b), .cmd_op(c2_op), .cmd_expect(c2_expect),
      .alu_a(a2_a), .alu_b(a2_b), .alu_ctrl(a2_ctrl), .alu_result(a2_result),
      .rsp_valid(r2_valid), .rsp_ready(r2_ready),
      .rsp_result(r2_result), .rsp_pass(r2_pass),
      .clear_counts(c2_clear), .pass_count(p2_count), .fail_count(f2_count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One command on unit 1, with hold cycles of response backpressure
   task automatic do_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic [3:0] ex, input int hold, input bit clr, input string tag);
      int r;
      bit p;
      r = model_alu(int'(a), int'(b), int'(op));
      p = (r == int'(ex));
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_expect = ex; rsp_ready = 1'b0;
      tick;  // accept edge k
      cmd_valid = 1'b0; cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom); cmd_expect = 4'($urandom);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL %s drive_cmd_ready got %b want 0", tag, cmd_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s drive_rsp_valid got %b want 0", tag, rsp_valid); end
      checks++; if ({alu_a, alu_b, alu_ctrl} !== {a, b, op}) begin errors++; $display("FAIL %s alu_drive got %h/%h/%h want %h/%h/%h", tag, alu_a, alu_b, alu_ctrl, a, b, op); end
      clear_counts = clr;
      tick;  // capture edge k+1
      clear_counts = 1'b0;
      if (clr) begin
         pass_m = 0; fail_m = 0;
      end else if (p) begin
         pass_m = (pass_m < 255) ? pass_m + 1 : 255;
      end else begin
         fail_m = (fail_m < 255) ? fail_m + 1 : 255;
      end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s rsp_valid got %b want 1", tag, rsp_valid); end
      checks++; if (rsp_result !== 4'(r)) begin errors++; $display("FAIL %s rsp_result got %h want %h", tag, rsp_result, 4'(r)); end
      checks++; if (rsp_pass !== p) begin errors++; $display("FAIL %s rsp_pass got %b want %b", tag, rsp_pass, p); end
      checks++; if (pass_count !== 8'(pass_m)) begin errors++; $display("FAIL %s pass_count got %0d want %0d", tag, pass_count, pass_m); end
      checks++; if (fail_count !== 8'(fail_m)) begin errors++; $display("FAIL %s fail_count got %0d want %0d", tag, fail_count, fail_m); end
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'($urandom); cmd_a = 4'($urandom); cmd_op = 3'($urandom);
         tick;
         checks++; if ({rsp_valid, cmd_ready} !== 2'b10) begin errors++; $display("FAIL %s hold_flags got %b%b want 10", tag, rsp_valid, cmd_ready); end
         checks++; if ({rsp_result, rsp_pass} !== {4'(r), p}) begin errors++; $display("FAIL %s hold_rsp got %h/%b want %h/%b", tag, rsp_result, rsp_pass, 4'(r), p); end
         checks++; if (alu_a !== a) begin errors++; $display("FAIL %s hold_alu_a got %h want %h", tag, alu_a, a); end
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      tick;  // response completes, back to IDLE
      rsp_ready = 1'b0;
      checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL %s idle_flags got %b%b want 10", tag, cmd_ready, rsp_valid); end
      checks++; if ({rsp_result, rsp_pass} !== {4'(r), p}) begin errors++; $display("FAIL %s idle_rsp got %h/%b want %h/%b", tag, rsp_result, rsp_pass, 4'(r), p); end
      checks++; if ({alu_a, alu_b, alu_ctrl} !== {a, b, op}) begin errors++; $display("FAIL %s idle_alu got %h/%h/%h want %h/%h/%h", tag, alu_a, alu_b, alu_ctrl, a, b, op); end
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b1; cmd_a = 4'hF; cmd_b = 4'hF; cmd_op = 3'h7;
      tick; tick;
      checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL reset_flags got %b%b want 10", cmd_ready, rsp_valid); end
      checks++; if ({alu_a, alu_b, alu_ctrl, rsp_result, rsp_pass} !== 16'h0) begin errors++; $display("FAIL reset_data got %h/%h/%h/%h/%b want 0", alu_a, alu_b, alu_ctrl, rsp_result, rsp_pass); end
      checks++; if ({pass_count, fail_count} !== 16'h0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", pass_count, fail_count); end
      checks++; if ({c2_ready, r2_valid, p2_count, f2_count} !== 18'h20000) begin errors++; $display("FAIL reset_unit2 got %b%b %0d %0d want 10 0 0", c2_ready, r2_valid, p2_count, f2_count); end
      cmd_valid = 1'b0;
      rst = 1'b0;
      tick;
      checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL post_reset_flags got %b%b want 10", cmd_ready, rsp_valid); end
   endtask

   // Reset in DRIVE, then in RESP: command aborted, no response, counts stay 0
   task automatic test_reset_abort;
      for (int s = 1; s <= 2; s++) begin
         cmd_valid = 1'b1; cmd_a = 4'hC; cmd_b = 4'hA; cmd_op = 3'b000; cmd_expect = 4'h8;
         tick;
         cmd_valid = 1'b0;
         if (s == 2) tick;
         rst = 1'b1;
         #1;
         checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL abort%0d_flags got %b%b want 10", s, cmd_ready, rsp_valid); end
         checks++; if ({alu_a, alu_b, alu_ctrl, rsp_result, rsp_pass} !== 16'h0) begin errors++; $display("FAIL abort%0d_data got %h/%h/%h/%h/%b want 0", s, alu_a, alu_b, alu_ctrl, rsp_result, rsp_pass); end
         tick;
         rst = 1'b0;
         tick; tick;
         checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL abort%0d_after got %b%b want 10", s, cmd_ready, rsp_valid); end
         checks++; if ({pass_count, fail_count} !== 16'h0) begin errors++; $display("FAIL abort%0d_counts got %0d/%0d want 0/0", s, pass_count, fail_count); end
      end
      pass_m = 0; fail_m = 0;
   endtask

   task automatic test_directed;
      do_cmd(4'b1100, 4'b1010, 3'b000, 4'b1000, 0, 1'b0, "and");
      do_cmd(4'b0100, 4'b0010, 3'b011, 4'b0011, 0, 1'b0, "sub_mismatch");
      do_cmd(4'b1111, 4'b0001, 3'b010, 4'b0000, 0, 1'b0, "add_wrap");
   endtask

   task automatic test_backpressure;
      do_cmd(4'b0110, 4'b0011, 3'b100, 4'b0101, 5, 1'b0, "backpressure");
   endtask

   task automatic test_random;
      logic [3:0] a, b, ex;
      logic [2:0] op;
      for (int n = 0; n < 40; n++) begin
         a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
         ex = ($urandom_range(0, 1) == 1) ? 4'(model_alu(int'(a), int'(b), int'(op))) : 4'($urandom);
         do_cmd(a, b, op, ex, int'($urandom_range(0, 3)), 1'b0, "random");
      end
   endtask

   task automatic test_saturation;
      logic [3:0] a, b;
      logic [2:0] op;
      for (int n = 0; n < 260; n++) begin
         a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
         do_cmd(a, b, op, 4'(model_alu(int'(a), int'(b), int'(op))), 0, 1'b0, "saturate");
      end
      checks++; if (pass_count !== 8'd255) begin errors++; $display("FAIL saturate_final got %0d want 255", pass_count); end
   endtask

   task automatic test_clear;
      do_cmd(4'h3, 4'h5, 3'b001, 4'h7, 0, 1'b1, "clear_vs_capture");
      checks++; if ({pass_count, fail_count} !== 16'h0) begin errors++; $display("FAIL clear_result got %0d/%0d want 0/0", pass_count, fail_count); end
      do_cmd(4'h3, 4'h5, 3'b001, 4'h7, 0, 1'b0, "after_clear");
   endtask

   // NOT on the SETTLE_CYCLES=4 unit: operands held 4 edges, response after k+4
   task automatic test_settle4;
      c2_valid = 1'b1; c2_a = 4'b1100; c2_b = 4'b0101; c2_op = 3'b111; c2_expect = 4'b0011;
      tick;  // edge k
      c2_valid = 1'b0; c2_a = 4'($urandom); c2_b = 4'($urandom); c2_op = 3'($urandom);
      for (int i = 0; i < 4; i++) begin
         checks++; if ({a2_a, a2_b, a2_ctrl} !== {4'b1100, 4'b0101, 3'b111}) begin errors++; $display("FAIL settle4_alu%0d got %h/%h/%h want c/5/7", i, a2_a, a2_b, a2_ctrl); end
         checks++; if ({r2_valid, c2_ready} !== 2'b00) begin errors++; $display("FAIL settle4_flags%0d got %b%b want 00", i, r2_valid, c2_ready); end
         c2_valid = 1'($urandom);
         tick;
      end
      c2_valid = 1'b0;
      checks++; if (r2_valid !== 1'b1) begin errors++; $display("FAIL settle4_valid got %b want 1", r2_valid); end
      checks++; if ({r2_result, r2_pass} !== {4'b0011, 1'b1}) begin errors++; $display("FAIL settle4_rsp got %h/%b want 3/1", r2_result, r2_pass); end
      checks++; if ({p2_count, f2_count} !== {8'd1, 8'd0}) begin errors++; $display("FAIL settle4_counts got %0d/%0d want 1/0", p2_count, f2_count); end
      r2_ready = 1'b1;
      tick;
      r2_ready = 1'b0;
      checks++; if ({c2_ready, r2_valid} !== 2'b10) begin errors++; $display("FAIL settle4_done got %b%b want 10", c2_ready, r2_valid); end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_reset_abort;
      test_directed;
      test_backpressure;
      test_random;
      test_saturation;
      test_clear;
      test_settle4;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
